// File: rtl/block_mem.sv
// Single-port write-first block RAM with a registered read and an out-of-range flag.
// Defining BLOCK_MEM_OUTREG_EN adds a second output register, so read latency becomes 2 cycles.
module block_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 98304,
  parameter int ADDR_W = 32,
  parameter int NB_WE  = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic [NB_WE-1:0]  wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [WIDTH-1:0]  dina,
  output logic [WIDTH-1:0]  douta,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] merged_d;
  logic [WIDTH-1:0] douta_d;
  logic             wr_en;
  logic [WIDTH-1:0] douta_q;
  logic             err_q;

  // The full address takes part in the range check, so high bits never alias onto a valid word.
  assign in_range = (addra < ADDR_W'(DEPTH));
  assign idx      = addra[IDX_W-1:0];

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < NB_WE; i++) begin
      if (NB_WE == 1) wmask = {WIDTH{wea[i]}};
      else            wmask[i*8 +: 8] = {8{wea[i]}};
    end
  end

  assign rd_word  = mem[idx];
  assign merged_d = (rd_word & ~wmask) | (dina & wmask);
  assign wr_en    = in_range && (|wmask);
  assign douta_d  = in_range ? merged_d : '0;

  always_ff @(posedge clka) begin
    if (!rsta && wr_en) mem[idx] <= merged_d;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      douta_q <= '0;
      err_q   <= 1'b0;
    end else begin
      douta_q <= douta_d;
      err_q   <= !in_range;
    end
  end

`ifdef BLOCK_MEM_OUTREG_EN
  logic [WIDTH-1:0] douta2_q;
  logic             err2_q;

  always_ff @(posedge clka) begin
    if (rsta) begin
      douta2_q <= '0;
      err2_q   <= 1'b0;
    end else begin
      douta2_q <= douta_q;
      err2_q   <= err_q;
    end
  end

  assign douta    = douta2_q;
  assign addr_err = err2_q;
`else
  assign douta    = douta_q;
  assign addr_err = err_q;
`endif

endmodule

// File: tb/tb_block_mem.sv
// Directed scoreboard bench for block_mem: expected words are queued at drive time and checked at output.
module tb_block_mem;

  localparam int W  = 32;
  localparam int D  = 256;
  localparam int AW = 32;
  localparam int NB = 4;
`ifdef BLOCK_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] we;
  logic [AW-1:0] addr;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          err;

  always #5 clk = ~clk;

  block_mem #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NB_WE(NB)) dut (
    .clka    (clk),
    .rsta    (rst),
    .wea     (we),
    .addra   (addr),
    .dina    (din),
    .douta   (dout),
    .addr_err(err)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [D];
  int           checks = 0;
  int           fails  = 0;

  task automatic step(input logic r, input logic [NB-1:0] w, input logic [AW-1:0] a,
                      input logic [W-1:0] di, input string tag);
    exp_t         e;
    exp_t         got;
    logic [W-1:0] cur;
    rst  = r;
    we   = w;
    addr = a;
    din  = di;
    e    = '0;
    if (r) begin
      for (int i = 0; i < sb.size(); i++) sb[i] = '0;
    end else if (a >= AW'(D)) begin
      e.e = 1'b1;
    end else begin
      cur = model[a];
      for (int i = 0; i < NB; i++) if (w[i]) cur[i*8 +: 8] = di[i*8 +: 8];
      model[a] = cur;
      e.d      = cur;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    assert (dout === got.d) else begin
      fails++;
      $error("FAIL %s douta=%h expected=%h", tag, dout, got.d);
    end
    checks++;
    assert (err === got.e) else begin
      fails++;
      $error("FAIL %s addr_err=%b expected=%b", tag, err, got.e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (model[i]) model[i] = '0;
    for (int i = 0; i < LAT - 1; i++) sb.push_back('0);
    rst  = 1'b1;
    we   = '0;
    addr = '0;
    din  = '0;

    step(1'b1, 4'hF, 32'd5, 32'h0000AAAA, "reset0");
    step(1'b1, 4'hF, 32'd5, 32'h0000AAAA, "reset1");
    step(1'b0, 4'h0, 32'd5, 32'h0,        "post_reset_rd5");

    for (int i = 0; i < D; i++) step(1'b0, 4'hF, AW'(i), W'(i), "fill");
    for (int i = 0; i < D; i++) step(1'b0, 4'h0, AW'(i), 32'hDEADBEEF, "readback1");
    for (int i = 0; i < D; i++) step(1'b0, 4'h0, AW'(i), 32'h0, "readback2");

    step(1'b0, 4'hF, 32'd256,        32'h00001234, "oor_write");
    step(1'b0, 4'h0, 32'd0,          32'h0,        "oor_no_alias");
    step(1'b0, 4'hF, 32'h8000_0001,  32'h00005555, "oor_high_bits");
    step(1'b0, 4'h0, 32'd1,          32'h0,        "oor_high_no_alias");
    step(1'b0, 4'hF, 32'd255,        32'hCAFEF00D, "last_addr_write");
    step(1'b0, 4'h0, 32'd255,        32'h0,        "last_addr_read");

    step(1'b0, 4'hF, 32'd7, 32'h11223344, "be_full");
    step(1'b0, 4'h5, 32'd7, 32'hAABBCCDD, "be_partial");
    step(1'b0, 4'h0, 32'd7, 32'h0,        "be_read");
    step(1'b0, 4'hA, 32'd7, 32'h99887766, "be_upper");
    step(1'b0, 4'h0, 32'd7, 32'h0,        "be_read2");

    step(1'b0, 4'hF, 32'd3, 32'd9,  "rdw_init");
    step(1'b0, 4'hF, 32'd3, 32'd42, "rdw_write_first");
    step(1'b0, 4'h0, 32'd3, 32'd0,  "rdw_read");

    step(1'b0, 4'h0, 32'd10, 32'h0,        "hold_rd10");
    step(1'b0, 4'h0, 32'd10, 32'h0,        "hold_rd10_again");
    step(1'b1, 4'hF, 32'd10, 32'h77777777, "mid_reset");
    step(1'b0, 4'h0, 32'd10, 32'h0,        "mid_reset_dropped");
    step(1'b0, 4'hF, 32'd300, 32'h1,       "oor_then_reset");
    step(1'b1, 4'h0, 32'd0,  32'h0,        "reset_clears_err");
    step(1'b0, 4'h0, 32'd255, 32'h0,       "resume_read");

    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] ra;
      logic [NB-1:0] rw;
      ra = AW'($urandom_range(0, D + 8));
      rw = NB'($urandom_range(0, 15));
      step(1'b0, rw, ra, $urandom, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
